// File: rtl/asym_ram_pkg.sv
// Shared definitions for the asymmetric true-dual-port RAM.
// Contents:
//   RF / WF / NC - WRITE_MODE encodings (read-first, write-first, no-change)
//   log2_u       - ceil(log2(v)), used for lane/address-shift derivation
//   max_u/min_u  - integer max/min used for width and address derivation
package asym_ram_pkg;

    localparam int unsigned RF = 0;
    localparam int unsigned WF = 1;
    localparam int unsigned NC = 2;

    function automatic int unsigned log2_u(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/asym_ram_tdp_sc_if.sv
// Bus bundle for asym_ram_tdp_sc: both access ports plus the collision flag.
// Signals:
//   enA/weA/addrA/diA  port A enable, write, address, write data (master -> slave)
//   doA/vldA           port A read data and read-valid strobe     (slave -> master)
//   enB/weB/addrB/diB  port B enable, write, address, write data (master -> slave)
//   doB/vldB           port B read data and read-valid strobe     (slave -> master)
//   collision          registered cross-port overlap pulse         (slave -> master)
interface asym_ram_tdp_sc_if #(
    parameter int unsigned WIDTHA     = 16,
    parameter int unsigned ADDRWIDTHA = 8,
    parameter int unsigned WIDTHB     = 4,
    parameter int unsigned ADDRWIDTHB = 10
);

    logic                  enA;
    logic                  weA;
    logic [ADDRWIDTHA-1:0] addrA;
    logic [WIDTHA-1:0]     diA;
    logic [WIDTHA-1:0]     doA;
    logic                  vldA;

    logic                  enB;
    logic                  weB;
    logic [ADDRWIDTHB-1:0] addrB;
    logic [WIDTHB-1:0]     diB;
    logic [WIDTHB-1:0]     doB;
    logic                  vldB;

    logic                  collision;

    modport master (
        output enA, weA, addrA, diA,
        output enB, weB, addrB, diB,
        input  doA, vldA, doB, vldB, collision
    );

    modport slave (
        input  enA, weA, addrA, diA,
        input  enB, weB, addrB, diB,
        output doA, vldA, doB, vldB, collision
    );

endinterface

// File: rtl/asym_ram_out_stage.sv
// Optional output register for one RAM port: data + valid.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   data_i      read data from the array stage
//   valid_i     read-valid strobe aligned with data_i
//   data_o      read data to the port (holds when no new valid)
//   valid_o     read-valid strobe aligned with data_o
// With OUT_REG=0 the stage is a pure wire.
module asym_ram_out_stage #(
    parameter int unsigned W       = 8,
    parameter int unsigned OUT_REG = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] data_i,
    input  logic         valid_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    if (OUT_REG != 0) begin : g_reg
        logic [W-1:0] data_q;
        logic         valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_i;
                if (valid_i) begin
                    data_q <= data_i;
                end
            end
        end

        assign data_o  = data_q;
        assign valid_o = valid_q;
    end else begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign data_o  = data_i;
        assign valid_o = valid_i;
    end

endmodule

// File: rtl/asym_ram_tdp_sc.sv
// Single-clock true-dual-port RAM with asymmetric port widths.
// One storage array of minW-wide words; the wide port touches RATIO
// consecutive narrow words per access (lane 0 = least significant bits).
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset (clears pipeline, blocks writes)
//   bus    slave modport of asym_ram_tdp_sc_if (both ports + collision)
// Read latency is 1 + OUT_REG; collision is aligned with the vld of the
// access cycle that overlapped.
module asym_ram_tdp_sc
    import asym_ram_pkg::*;
#(
    parameter int unsigned WIDTHA     = 16,
    parameter int unsigned ADDRWIDTHA = 8,
    parameter int unsigned WIDTHB     = 4,
    parameter int unsigned ADDRWIDTHB = 10,
    parameter int unsigned WRITE_MODE = RF,
    parameter int unsigned OUT_REG    = 0
) (
    input logic              clk,
    input logic              rst_n,
    asym_ram_tdp_sc_if.slave bus
);

    localparam int unsigned maxW   = max_u(WIDTHA, WIDTHB);
    localparam int unsigned minW   = min_u(WIDTHA, WIDTHB);
    localparam int unsigned RATIO  = maxW / minW;
    localparam int unsigned LOG2R  = log2_u(RATIO);
    localparam int unsigned NADDRW = max_u(ADDRWIDTHA, ADDRWIDTHB);
    localparam int unsigned LANESA = WIDTHA / minW;
    localparam int unsigned LANESB = WIDTHB / minW;
    localparam int unsigned SHA    = log2_u(LANESA);
    localparam int unsigned SHB    = log2_u(LANESB);
    localparam bit          A_WIDE = (WIDTHA >= WIDTHB);

    if ((maxW % minW) != 0 || (32'd1 << LOG2R) != RATIO) begin : g_bad_ratio
        $error("asym_ram_tdp_sc: wide width must be a power-of-2 multiple of narrow width");
    end
    if (A_WIDE ? (ADDRWIDTHB != ADDRWIDTHA + LOG2R)
               : (ADDRWIDTHA != ADDRWIDTHB + LOG2R)) begin : g_bad_addr
        $error("asym_ram_tdp_sc: narrow address width must equal wide address width + log2(RATIO)");
    end
    if (WRITE_MODE > NC || OUT_REG > 1) begin : g_bad_mode
        $error("asym_ram_tdp_sc: WRITE_MODE must be 0..2 and OUT_REG 0..1");
    end

    logic [minW-1:0]   mem [2**NADDRW];

    logic [NADDRW-1:0] base_a;
    logic [NADDRW-1:0] base_b;
    logic              wr_a;
    logic              wr_b;
    logic              overlap;

    logic [WIDTHA-1:0] mem_rd_a;
    logic [WIDTHB-1:0] mem_rd_b;

    logic [WIDTHA-1:0] rd_a_d;
    logic [WIDTHA-1:0] rd_a_q;
    logic              vld_a_d;
    logic              vld_a_q;
    logic [WIDTHB-1:0] rd_b_d;
    logic [WIDTHB-1:0] rd_b_q;
    logic              vld_b_d;
    logic              vld_b_q;
    logic              col_d;
    logic              col_q;

    // First narrow word touched by each port.
    assign base_a = NADDRW'(bus.addrA) << SHA;
    assign base_b = NADDRW'(bus.addrB) << SHB;

    assign wr_a = bus.enA && bus.weA;
    assign wr_b = bus.enB && bus.weB;

    // Both ranges are aligned blocks no larger than RATIO words, so they
    // intersect exactly when they sit in the same RATIO-word block.
    assign overlap = bus.enA && bus.enB && ((base_a >> LOG2R) == (base_b >> LOG2R));
    assign col_d   = overlap && (wr_a || wr_b);

    // Lane write-mux: port B is applied first so port A's later
    // non-blocking assignment wins on any overlapping lane. The reset
    // event does nothing here; it only keeps writes off while rst_n=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n) begin
            if (wr_b) begin
                for (int unsigned k = 0; k < LANESB; k++) begin
                    mem[base_b | NADDRW'(k)] <= bus.diB[k*minW +: minW];
                end
            end
            if (wr_a) begin
                for (int unsigned k = 0; k < LANESA; k++) begin
                    mem[base_a | NADDRW'(k)] <= bus.diA[k*minW +: minW];
                end
            end
        end
    end

    // Array contents before this edge's writes: cross-port readers always
    // see old data, as does a READ_FIRST same-port write.
    always_comb begin
        mem_rd_a = '0;
        for (int unsigned k = 0; k < LANESA; k++) begin
            mem_rd_a[k*minW +: minW] = mem[base_a | NADDRW'(k)];
        end
    end

    always_comb begin
        mem_rd_b = '0;
        for (int unsigned k = 0; k < LANESB; k++) begin
            mem_rd_b[k*minW +: minW] = mem[base_b | NADDRW'(k)];
        end
    end

    assign vld_a_d = bus.enA && !(bus.weA && WRITE_MODE == NC);
    assign rd_a_d  = (bus.weA && WRITE_MODE == WF) ? bus.diA : mem_rd_a;
    assign vld_b_d = bus.enB && !(bus.weB && WRITE_MODE == NC);
    assign rd_b_d  = (bus.weB && WRITE_MODE == WF) ? bus.diB : mem_rd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_q  <= '0;
            vld_a_q <= 1'b0;
            rd_b_q  <= '0;
            vld_b_q <= 1'b0;
            col_q   <= 1'b0;
        end else begin
            vld_a_q <= vld_a_d;
            vld_b_q <= vld_b_d;
            col_q   <= col_d;
            if (vld_a_d) begin
                rd_a_q <= rd_a_d;
            end
            if (vld_b_d) begin
                rd_b_q <= rd_b_d;
            end
        end
    end

    asym_ram_out_stage #(
        .W       (WIDTHA),
        .OUT_REG (OUT_REG)
    ) u_out_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (rd_a_q),
        .valid_i (vld_a_q),
        .data_o  (bus.doA),
        .valid_o (bus.vldA)
    );

    asym_ram_out_stage #(
        .W       (WIDTHB),
        .OUT_REG (OUT_REG)
    ) u_out_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (rd_b_q),
        .valid_i (vld_b_q),
        .data_o  (bus.doB),
        .valid_o (bus.vldB)
    );

    // Collision follows the same pipeline depth as the read data.
    if (OUT_REG != 0) begin : g_col_reg
        logic col_o_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                col_o_q <= 1'b0;
            end else begin
                col_o_q <= col_q;
            end
        end

        assign bus.collision = col_o_q;
    end else begin : g_col_bypass
        assign bus.collision = col_q;
    end

endmodule

// File: tb/tb_asym_ram_tdp_sc.sv
// Scoreboard bench for asym_ram_tdp_sc (16-bit port A, 4-bit port B).
// Three instances share one stimulus stream: READ_FIRST/OUT_REG=0,
// WRITE_FIRST/OUT_REG=1 and NO_CHANGE/OUT_REG=0. A narrow-word array model
// produces expected read results that are queued at issue time with the
// cycle they are due; per-instance monitors pop and compare.
module tb_asym_ram_tdp_sc;
    import asym_ram_pkg::*;

    localparam int NINST = 3;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic [15:0] mask;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        enA, weA, enB, weB;
    logic [7:0]  addrA;
    logic [15:0] diA;
    logic [9:0]  addrB;
    logic [3:0]  diB;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit release_now = 1'b0;

    exp_t        qa [NINST][$];
    exp_t        qb [NINST][$];
    int          cq [NINST][$];
    logic [15:0] ha [NINST];
    logic [15:0] ma [NINST];
    logic [15:0] hb [NINST];
    logic [15:0] mb [NINST];

    // Reference storage: 1024 nibbles, plus which ones hold known data.
    logic [3:0] mm    [1024];
    bit         known [1024];

    function automatic int unsigned wm_of(input int i);
        return (i == 1) ? WF : (i == 2) ? NC : RF;
    endfunction

    function automatic int unsigned or_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NINST; gi++) begin : g_dut
        asym_ram_tdp_sc_if #(
            .WIDTHA(16), .ADDRWIDTHA(8), .WIDTHB(4), .ADDRWIDTHB(10)
        ) bus ();

        assign bus.enA   = enA;
        assign bus.weA   = weA;
        assign bus.addrA = addrA;
        assign bus.diA   = diA;
        assign bus.enB   = enB;
        assign bus.weB   = weB;
        assign bus.addrB = addrB;
        assign bus.diB   = diB;

        asym_ram_tdp_sc #(
            .WIDTHA     (16),
            .ADDRWIDTHA (8),
            .WIDTHB     (4),
            .ADDRWIDTHB (10),
            .WRITE_MODE (wm_of(gi)),
            .OUT_REG    (or_of(gi))
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        always @(posedge clk) begin
            #1;
            monitor(gi, bus.doA, bus.vldA, bus.doB, bus.vldB, bus.collision);
        end
    end

    task automatic chk(input string name, input int i, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d got %h expected %h", name, i, cyc, act, exp);
        end
    endtask

    task automatic monitor(input int i, input logic [15:0] doa, input logic va,
                           input logic [3:0] dob, input logic vb, input logic col);
        exp_t x;
        bit   ev;
        if (!rst_n) begin
            chk("rst_doA", i, doa, 16'h0);
            chk("rst_vldA", i, 16'(va), 16'h0);
            chk("rst_doB", i, 16'(dob), 16'h0);
            chk("rst_vldB", i, 16'(vb), 16'h0);
            chk("rst_collision", i, 16'(col), 16'h0);
        end else begin
            ev = qa[i].size() != 0 && qa[i][0].due == cyc;
            chk("vldA", i, 16'(va), 16'(ev));
            if (ev) begin
                x = qa[i].pop_front();
                if (va) chk("doA", i, doa & x.mask, x.data & x.mask);
                ha[i] = x.data;
                ma[i] = x.mask;
            end else if (!va) begin
                chk("doA_hold", i, doa & ma[i], ha[i] & ma[i]);
            end

            ev = qb[i].size() != 0 && qb[i][0].due == cyc;
            chk("vldB", i, 16'(vb), 16'(ev));
            if (ev) begin
                x = qb[i].pop_front();
                if (vb) chk("doB", i, 16'(dob) & x.mask, x.data & x.mask);
                hb[i] = x.data;
                mb[i] = x.mask;
            end else if (!vb) begin
                chk("doB_hold", i, 16'(dob) & mb[i], hb[i] & mb[i]);
            end

            ev = cq[i].size() != 0 && cq[i][0] == cyc;
            if (ev) void'(cq[i].pop_front());
            chk("collision", i, 16'(col), 16'(ev));
        end
    endtask

    // Drive one access cycle and predict every instance's response.
    task automatic access(input logic ea, input logic wa, input logic [7:0] aa, input logic [15:0] da,
                          input logic eb, input logic wb, input logic [9:0] ab, input logic [3:0] db);
        int          base;
        int          e;
        logic [15:0] olda;
        logic [15:0] mska;
        bit          ovl;
        exp_t        x;
        @(negedge clk);
        enA = ea; weA = wa; addrA = aa; diA = da;
        enB = eb; weB = wb; addrB = ab; diB = db;
        if (release_now) begin
            rst_n       = 1'b1;
            release_now = 1'b0;
        end
        if (rst_n) begin
            e    = cyc + 1;
            base = int'(aa) * 4;
            for (int k = 0; k < 4; k++) begin
                olda[k*4 +: 4] = mm[base + k];
                mska[k*4 +: 4] = known[base + k] ? 4'hF : 4'h0;
            end
            ovl = ea && eb && int'(ab) >= base && int'(ab) < base + 4;
            for (int i = 0; i < NINST; i++) begin
                if (ea && !(wa && wm_of(i) == NC)) begin
                    x.due = e + or_of(i);
                    if (wa && wm_of(i) == WF) begin
                        x.data = da;
                        x.mask = 16'hFFFF;
                    end else begin
                        x.data = olda;
                        x.mask = mska;
                    end
                    qa[i].push_back(x);
                end
                if (eb && !(wb && wm_of(i) == NC)) begin
                    x.due = e + or_of(i);
                    if (wb && wm_of(i) == WF) begin
                        x.data = {12'h0, db};
                        x.mask = 16'h000F;
                    end else begin
                        x.data = {12'h0, mm[ab]};
                        x.mask = known[ab] ? 16'h000F : 16'h0000;
                    end
                    qb[i].push_back(x);
                end
                if (ovl && (wa || wb)) cq[i].push_back(e + or_of(i));
            end
            if (eb && wb) begin
                mm[ab]    = db;
                known[ab] = 1'b1;
            end
            if (ea && wa) begin
                for (int k = 0; k < 4; k++) begin
                    mm[base + k]    = da[k*4 +: 4];
                    known[base + k] = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) access(1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b0, 10'h0, 4'h0);
    endtask

    // Assert reset (dropping anything in flight), apply random writes while
    // held, and arrange for the next access to release it.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < NINST; i++) begin
            qa[i].delete();
            qb[i].delete();
            cq[i].delete();
            ha[i] = 16'h0; ma[i] = 16'hFFFF;
            hb[i] = 16'h0; mb[i] = 16'hFFFF;
        end
        repeat (n) access(1'b1, 1'b1, 8'($urandom), 16'($urandom),
                          1'($urandom), 1'($urandom), 10'($urandom), 4'($urandom));
        release_now = 1'b1;
    endtask

    initial begin
        enA = 0; weA = 0; addrA = '0; diA = '0;
        enB = 0; weB = 0; addrB = '0; diB = '0;
        for (int i = 0; i < NINST; i++) begin
            ha[i] = 16'h0; ma[i] = 16'hFFFF;
            hb[i] = 16'h0; mb[i] = 16'hFFFF;
        end
        for (int j = 0; j < 1024; j++) begin
            mm[j] = 4'h0;
            known[j] = 1'b0;
        end
        repeat (3) @(negedge clk);
        release_now = 1'b1;

        for (int a = 0; a < 256; a++)
            access(1'b1, 1'b1, 8'(a), 16'($urandom), 1'b0, 1'b0, 10'h0, 4'h0);

        // Wide write, narrow reads of each lane back to back.
        access(1'b1, 1'b1, 8'h05, 16'hDCBA, 1'b0, 1'b0, 10'h0, 4'h0);
        for (int k = 0; k < 4; k++)
            access(1'b0, 1'b0, 8'h0, 16'h0, 1'b1, 1'b0, 10'(16'h14 + k), 4'h0);
        idle(3);

        // Narrow writes assembled by a wide read.
        for (int k = 0; k < 4; k++)
            access(1'b0, 1'b0, 8'h0, 16'h0, 1'b1, 1'b1, 10'(16'h20 + k), 4'(k + 1));
        access(1'b1, 1'b0, 8'h08, 16'h0, 1'b0, 1'b0, 10'h0, 4'h0);
        idle(3);

        // Same-port write behaviour over a known old value.
        access(1'b1, 1'b1, 8'h40, 16'h1111, 1'b0, 1'b0, 10'h0, 4'h0);
        access(1'b1, 1'b1, 8'h40, 16'h2222, 1'b0, 1'b0, 10'h0, 4'h0);
        idle(3);

        // Write/write overlap: port A wins the shared lane.
        access(1'b1, 1'b1, 8'h00, 16'hFFFF, 1'b1, 1'b1, 10'h002, 4'h5);
        access(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 10'h0, 4'h0);
        idle(3);

        // Read/write overlap: B sees the old lane, then the new one.
        access(1'b1, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 10'h0, 4'h0);
        access(1'b1, 1'b1, 8'h00, 16'h9876, 1'b1, 1'b0, 10'h003, 4'h0);
        access(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 10'h003, 4'h0);
        idle(3);

        // Reset with reads in flight, writes held off, first edge after release.
        access(1'b1, 1'b0, 8'h10, 16'h0, 1'b1, 1'b0, 10'h055, 4'h0);
        do_reset(6);
        access(1'b1, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 10'h001, 4'h0);
        idle(3);

        for (int n = 0; n < 1500; n++) begin
            logic [7:0] ra;
            logic [9:0] rb;
            ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
            access($urandom_range(0, 3) != 0, 1'($urandom), ra, 16'($urandom),
                   $urandom_range(0, 3) != 0, 1'($urandom), rb, 4'($urandom));
            if (n == 700) do_reset(4);
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/asym_ram_tdp_sc.md
# asym_ram_tdp_sc

Single-clock true-dual-port RAM with asymmetric port widths, parametrised in width ratio, depth, write mode and output pipelining. Port A and port B see one shared storage array at different granularities; the wide port addresses RATIO consecutive narrow words at once. It adds per-port enables, read-valid strobes, an optional output register and registered cross-port collision detection. It is the generic memory primitive for width-converting buffers in single-clock datapaths.

## Interface
- WIDTHA, 16, port A data width
- ADDRWIDTHA, 8, port A address width
- WIDTHB, 4, port B data width
- ADDRWIDTHB, 10, port B address width
- WRITE_MODE, 0, 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE (same-port behaviour)
- OUT_REG, 0, 1 adds an output register stage on both ports
- Legal configurations: max width = RATIO × min width, with RATIO a power of 2 (≥1). Narrow-port address width = wide-port address width + log2(RATIO). Any other configuration is a `$error` at elaboration.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enA  in  1  port A access enable
- weA  in  1  port A write (qualified by enA)
- addrA  in  ADDRWIDTHA  port A address
- diA  in  WIDTHA  port A write data
- doA  out  WIDTHA  port A read data
- vldA  out  1  doA holds new read data this cycle
- enB, weB, addrB, diB, doB, vldB: the same as the port A signals, for port B
- collision  out  1  registered pulse: the ports overlapped in the previous access cycle

## Operation
- Storage is an array of 2^ADDRWIDTH_narrow words, each min width wide. Memory is not reset.
- Wide-port address `a` covers narrow words {a, k} for k = 0..RATIO-1.
  - Lane k maps to wide data bits [(k+1)·minW-1 : k·minW].
  - Lane 0 is least significant.
- Access: en=1 and we=0 is a read. en=1 and we=1 is a write. en=0 is idle: do holds, vld=0.
- Same-port read data during a write, by WRITE_MODE:
  - READ_FIRST: do = old contents.
  - WRITE_FIRST: do = di.
  - NO_CHANGE: do holds its previous value and vld stays 0.
- Overlap: both ports enabled and the narrow-word ranges intersect.
- Write/write overlap: port A data wins on the overlapping lanes. Port B's non-overlapping lanes are written normally.
- Read/write overlap across ports: the reader always gets the old contents, whatever WRITE_MODE is.
- Any overlap where at least one port writes sets collision. Read/read overlap does not flag.
- While rst_n=0, all writes are suppressed.

## Timing
- Read latency is 1 + OUT_REG cycles from the enabled edge to do/vld.
- vld is a pulse aligned with its data. Back-to-back reads give one result per cycle with no bubbles.
- collision is asserted 1 + OUT_REG cycles after the overlapping edge, so it is aligned with that access's vld. It stays high for one cycle per overlapping cycle.
- Reset values: doA=0, doB=0, vldA=0, vldB=0, collision=0. All pipeline stages clear asynchronously.
- Reset asserted mid-read: the in-flight vld is dropped and never appears after reset is released.
- First access is accepted on the first rising edge with rst_n=1.
- Address wrap-around: none. The address spaces are exact powers of 2.

## Structure
- Package asym_ram_pkg holds:
  - WRITE_MODE constants RF/WF/NC.
  - A clog2-style log2 function.
  - max/min functions, used instead of macros.
- The localparams RATIO, minW, maxW and the narrow address width are derived in the module from package functions.
- Sub-module asym_ram_out_stage is instantiated once per port. It is a parameterised width + valid register with async reset and a bypass when OUT_REG=0.
- The core array and the lane write-mux stay in the top module.

## Test plan
- Reset: hold rst_n=0 with weA=1 and random stimulus. Required: all outputs 0 and no memory change; a subsequent read of address 0 returns its previously written value.
- Wide write, narrow read (16/4): write A addr 0x05 = 0xDCBA, then read B addr 0x14..0x17. Required: 0xA, 0xB, 0xC, 0xD, each with vldB, at latency 1 and at latency 2 with OUT_REG=1.
- Narrow write, wide read: write B 0x20=0x1, 0x21=0x2, 0x22=0x3, 0x23=0x4, then read A 0x08. Required: doA=0x4321.
- Write modes: location holds 0x1111; write A with 0x2222 at the same address.
  - RF: doA=0x1111.
  - WF: doA=0x2222.
  - NC: doA unchanged, vldA=0.
- Write/write collision: same cycle, A writes addr 0x00=0xFFFF and B writes addr 0x02=0x5. Required: collision pulses 1 cycle later; a later read of A 0x00 = 0xFFFF.
- Read/write collision: B reads 0x03 while A writes 0x00=0x9876 (old value 0x0000). Required: doB=0x0, collision=1. A following B read of 0x03 returns 0x9.
